// File: rtl/heart_beat_pkg.sv
// -----------------------------------------------------------------------------
// heart_beat_pkg
// Shared timing model for the heartbeat generator and the heartbeat monitor.
// Both sides call hb_period() so that they agree on the nominal period.
//   hb_mon_state_t : monitor state encoding
//   RATE_DEBUG     : base rate used when IS_DEBUG = "true"
//   RATE_NORM      : base rate for normal builds
//   hb_period()    : nominal period P = 2*RATE/SPEED_GRADE in clocks
// -----------------------------------------------------------------------------
package heart_beat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } hb_mon_state_t;

  localparam int RATE_DEBUG = 120;
  localparam int RATE_NORM  = 120_000_000;

  // Unsupported speed grades fall back to a divider of 2.
  function automatic int hb_period(input int speed_grade, input bit is_debug);
    int rate;
    int grade;
    rate = is_debug ? RATE_DEBUG : RATE_NORM;
    case (speed_grade)
      2, 3, 5, 6: grade = speed_grade;
      default:    grade = 2;
    endcase
    return (2 * rate) / grade;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Multi-flop synchroniser for an asynchronous level input, followed by a
// registered rising-edge detector. A rising edge on i_d produces a one-cycle
// o_rise pulse STAGES+1 clocks after the transition.
//   i_clk   : clock
//   i_a_rst : asynchronous active-high reset (clears every flop)
//   i_d     : asynchronous input
//   o_q     : synchronised level
//   o_rise  : one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_a_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  // Fewer than two stages would not give metastability settling time.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] r_sync;
  logic         r_prev;
  logic         r_rise;

  // NOTE: sequential state is assigned with <= so that every flop samples the
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
      r_prev <= r_sync[N-1];
      r_rise <= r_sync[N-1] & ~r_prev;
    end
  end

  assign o_q    = r_sync[N-1];
  assign o_rise = r_rise;

endmodule

// File: rtl/heart_beat_monitor.sv
// -----------------------------------------------------------------------------
// heart_beat_monitor
// Receive side of the board heartbeat. Synchronises the incoming blink-mode
// heartbeat, measures the rising-edge to rising-edge period and checks it
// against a window of P +/- (P >> TOL_SHIFT). Reports lock, loss and errors.
//   i_clk        : system clock
//   i_a_rst      : asynchronous active-high reset
//   i_heart_beat : asynchronous heartbeat input
//   o_alive      : high while LOCKED
//   o_lost       : high while LOST (no edge within MAX_P clocks)
//   o_err        : one-cycle pulse on a bad period or on timeout entry
//   o_period     : last measured period in clocks
//   o_period_vld : one-cycle pulse when o_period updates
//   o_err_cnt    : saturating error count
// Build option: define HEART_BEAT_MON_ERR_CNT_EN to implement o_err_cnt;
// without it o_err_cnt is tied to zero.
// -----------------------------------------------------------------------------
module heart_beat_monitor
  import heart_beat_pkg::*;
#(
  parameter int    SPEED_GRADE = 2,
  parameter string IS_DEBUG    = "false",
  parameter int    TOL_SHIFT   = 3,
  parameter int    LOCK_COUNT  = 4,
  parameter int    SYNC_STAGES = 2,
  localparam int   P           = hb_period(SPEED_GRADE, IS_DEBUG == "true"),
  localparam int   TOL         = P >> TOL_SHIFT,
  localparam int   MIN_P       = P - TOL,
  localparam int   MAX_P       = P + TOL,
  localparam int   PW          = $clog2(MAX_P + 2)
) (
  input  logic          i_clk,
  input  logic          i_a_rst,
  input  logic          i_heart_beat,
  output logic          o_alive,
  output logic          o_lost,
  output logic          o_err,
  output logic [PW-1:0] o_period,
  output logic          o_period_vld,
  output logic [15:0]   o_err_cnt
);

  localparam logic [PW-1:0] MIN_V  = PW'(MIN_P);
  localparam logic [PW-1:0] MAX_V  = PW'(MAX_P);
  localparam logic [3:0]    LOCK_V = 4'(LOCK_COUNT - 1);

  logic          w_rise;
  logic          w_timeout;
  logic          w_in_win;

  hb_mon_state_t r_state;
  logic [PW-1:0] r_cnt;
  logic [3:0]    r_good_cnt;
  logic          r_alive;
  logic          r_lost;
  logic          r_err;
  logic [PW-1:0] r_period;
  logic          r_period_vld;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_a_rst (i_a_rst),
    .i_d     (i_heart_beat),
    .o_q     (),
    .o_rise  (w_rise)
  );

  // An edge in the same cycle the counter reaches MAX_P wins over timeout.
  assign w_timeout = (r_cnt == MAX_V) && !w_rise;
  assign w_in_win  = (r_cnt >= MIN_V) && (r_cnt <= MAX_V);

  // Edge-to-edge counter. It saturates at MAX_P, which also keeps it frozen
  // there while LOST.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= PW'(1);
    end else if (r_cnt != MAX_V) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      r_state      <= IDLE;
      r_good_cnt   <= '0;
      r_alive      <= 1'b0;
      r_lost       <= 1'b0;
      r_err        <= 1'b0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
    end else begin
      r_err        <= 1'b0;
      r_period_vld <= 1'b0;
      case (r_state)
        // First edge after reset only starts the measurement.
        IDLE: begin
          if (w_rise) begin
            r_state    <= ACQ;
            r_good_cnt <= '0;
          end
        end
        ACQ: begin
          if (w_rise) begin
            r_period     <= r_cnt;
            r_period_vld <= 1'b1;
            if (w_in_win) begin
              if (r_good_cnt == LOCK_V) begin
                r_state    <= LOCKED;
                r_alive    <= 1'b1;
                r_good_cnt <= '0;
              end else begin
                r_good_cnt <= r_good_cnt + 4'd1;
              end
            end else begin
              r_good_cnt <= '0;
              r_err      <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= LOST;
            r_lost  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_rise) begin
            r_period     <= r_cnt;
            r_period_vld <= 1'b1;
            if (!w_in_win) begin
              r_state    <= ACQ;
              r_alive    <= 1'b0;
              r_good_cnt <= '0;
              r_err      <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= LOST;
            r_alive <= 1'b0;
            r_lost  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        // The counter is stale here, so the recovering edge is not measured.
        LOST: begin
          if (w_rise) begin
            r_state    <= ACQ;
            r_lost     <= 1'b0;
            r_good_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_alive      = r_alive;
  assign o_lost       = r_lost;
  assign o_err        = r_err;
  assign o_period     = r_period;
  assign o_period_vld = r_period_vld;

`ifdef HEART_BEAT_MON_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      r_err_cnt <= '0;
    end else if (r_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_heart_beat_monitor.sv
// -----------------------------------------------------------------------------
// tb_heart_beat_monitor
// Directed bench for heart_beat_monitor with IS_DEBUG = "true" and defaults:
// P = 120, window 105..135, lock after 4 good periods. Heartbeat edges are
// driven 1 time unit after a rising clock edge, so edge spacing in clocks is
// exact. Expected error counts follow HEART_BEAT_MON_ERR_CNT_EN.
// -----------------------------------------------------------------------------
module tb_heart_beat_monitor;

`ifdef HEART_BEAT_MON_ERR_CNT_EN
  localparam bit ERR_CNT_ON = 1'b1;
`else
  localparam bit ERR_CNT_ON = 1'b0;
`endif

  logic        i_clk;
  logic        i_a_rst;
  logic        i_heart_beat;
  logic        o_alive;
  logic        o_lost;
  logic        o_err;
  logic [7:0]  o_period;
  logic        o_period_vld;
  logic [15:0] o_err_cnt;

  int n_checks;
  int n_fail;

  // Event log gathered on the falling edge.
  int   n_vld;
  int   n_err;
  int   last_period;
  logic alive_at_vld;
  logic err_at_vld;

  heart_beat_monitor #(
    .SPEED_GRADE (2),
    .IS_DEBUG    ("true"),
    .TOL_SHIFT   (3),
    .LOCK_COUNT  (4),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk        (i_clk),
    .i_a_rst      (i_a_rst),
    .i_heart_beat (i_heart_beat),
    .o_alive      (o_alive),
    .o_lost       (o_lost),
    .o_err        (o_err),
    .o_period     (o_period),
    .o_period_vld (o_period_vld),
    .o_err_cnt    (o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    n_vld        = 0;
    n_err        = 0;
    last_period  = 0;
    alive_at_vld = 1'b0;
    err_at_vld   = 1'b0;
  end

  always @(negedge i_clk) begin
    if (!i_a_rst) begin
      if (o_period_vld) begin
        n_vld        = n_vld + 1;
        last_period  = int'(o_period);
        alive_at_vld = o_alive;
        err_at_vld   = o_err;
      end
      if (o_err) n_err = n_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One heartbeat cycle of n clocks, starting with a rising edge now.
  task automatic beat(input int n);
    i_heart_beat = 1'b1;
    repeat (n / 2) step();
    i_heart_beat = 1'b0;
    repeat (n - n / 2) step();
  endtask

  function automatic int exp_cnt(input int k);
    return ERR_CNT_ON ? k : 0;
  endfunction

  int vld_before;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    i_a_rst      = 1'b1;
    i_heart_beat = 1'b0;
    repeat (3) step();
    i_a_rst = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_alive",   32'(o_alive),      32'd0);
    check("rst_lost",    32'(o_lost),       32'd0);
    check("rst_err",     32'(o_err),        32'd0);
    check("rst_period",  32'(o_period),     32'd0);
    check("rst_vld",     32'(o_period_vld), 32'd0);
    check("rst_err_cnt", 32'(o_err_cnt),    32'd0);

    // Acquire: first edge unmeasured, lock on the 4th measured 120 period
    repeat (4) beat(120);
    check("acq_alive_pre", 32'(o_alive), 32'd0);
    check("acq_n_vld3",    32'(n_vld),   32'd3);
    beat(120);
    check("lock_alive",     32'(o_alive),      32'd1);
    check("lock_n_vld",     32'(n_vld),        32'd4);
    check("lock_period",    32'(last_period),  32'd120);
    check("lock_with_vld",  32'(alive_at_vld), 32'd1);
    check("lock_no_err",    32'(n_err),        32'd0);

    // Short period while locked
    beat(100);
    beat(120);
    check("short_err",     32'(n_err),       32'd1);
    check("short_alive",   32'(o_alive),     32'd0);
    check("short_period",  32'(last_period), 32'd100);
    check("short_err_vld", 32'(err_at_vld),  32'd1);
    check("short_err_cnt", 32'(o_err_cnt),   32'(exp_cnt(1)));
    repeat (3) beat(120);
    check("relock_pre",    32'(o_alive),     32'd0);
    beat(120);
    check("relock_alive",  32'(o_alive),     32'd1);

    // Window boundaries: 105 and 135 accepted, 104 rejected
    beat(105);
    beat(135);
    check("b105_period", 32'(last_period), 32'd105);
    check("b105_alive",  32'(o_alive),     32'd1);
    beat(104);
    check("b135_period", 32'(last_period), 32'd135);
    check("b135_alive",  32'(o_alive),     32'd1);
    check("b135_no_err", 32'(n_err),       32'd1);
    check("b135_lost",   32'(o_lost),      32'd0);
    beat(120);
    check("b104_period",  32'(last_period), 32'd104);
    check("b104_err",     32'(n_err),       32'd2);
    check("b104_alive",   32'(o_alive),     32'd0);
    check("b104_err_cnt", 32'(o_err_cnt),   32'(exp_cnt(2)));

    // Timeout: counter hits 135 in the 139th cycle after the drive
    repeat (18) step();
    check("to_lost_pre", 32'(o_lost), 32'd0);
    step();
    check("to_lost",     32'(o_lost),  32'd1);
    check("to_err",      32'(o_err),   32'd1);
    check("to_alive",    32'(o_alive), 32'd0);
    step();
    check("to_err_once", 32'(o_err),     32'd0);
    check("to_err_cnt",  32'(o_err_cnt), 32'(exp_cnt(3)));
    check("to_n_err",    32'(n_err),     32'd3);

    // Recovery edge after LOST is not measured
    vld_before = n_vld;
    beat(120);
    check("rec_lost",   32'(o_lost),  32'd0);
    check("rec_no_vld", 32'(n_vld),   32'(vld_before));
    check("rec_alive",  32'(o_alive), 32'd0);
    repeat (4) beat(120);
    check("rec_lock",   32'(o_alive), 32'd1);
    check("rec_period", 32'(last_period), 32'd120);

    // Asynchronous reset between clock edges while LOCKED
    #2;
    i_a_rst = 1'b1;
    #1;
    check("arst_alive",   32'(o_alive),      32'd0);
    check("arst_lost",    32'(o_lost),       32'd0);
    check("arst_err",     32'(o_err),        32'd0);
    check("arst_period",  32'(o_period),     32'd0);
    check("arst_vld",     32'(o_period_vld), 32'd0);
    check("arst_err_cnt", 32'(o_err_cnt),    32'd0);
    repeat (2) step();
    i_a_rst = 1'b0;
    step();
    vld_before = n_vld;
    beat(120);
    check("post_rst_no_vld", 32'(n_vld), 32'(vld_before));
    beat(120);
    check("post_rst_vld",    32'(n_vld),       32'(vld_before + 1));
    check("post_rst_period", 32'(last_period), 32'd120);
    check("post_rst_alive",  32'(o_alive),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
